// File: rtl/memory_pkg.sv
// Shared types and constants for the 8-bit SRAM mem_bus responder.
// Covers the transaction phase enum, lane indices and mem_bus widths.
package memory_pkg;
   localparam int DATA_W     = 16;
   localparam int MASK_W     = 2;
   localparam int BUS_ADDR_W = 27;

   localparam logic LANE_EVEN = 1'b0;
   localparam logic LANE_ODD  = 1'b1;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_e;

   // Even lane carries the high byte of the bus word.
   function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] data, input logic lane);
      return (lane == LANE_EVEN) ? data[15:8] : data[7:0];
   endfunction
endpackage

// File: rtl/memory_sram8_responder_if.sv
// mem_bus transaction port: the controller drives request/command,
// the responder returns a one-cycle ack with read data.
interface mem_bus_if;
   import memory_pkg::*;
   logic                  request;
   logic                  write;
   logic [BUS_ADDR_W-1:0] address;
   logic [DATA_W-1:0]     wdata;
   logic [MASK_W-1:0]     wmask;
   logic                  ack;
   logic [DATA_W-1:0]     rdata;

   modport master (output request, write, address, wdata, wmask, input ack, rdata);
   modport slave  (input request, write, address, wdata, wmask, output ack, rdata);
endinterface

// File: rtl/memory_sram8_byte_cycle.sv
// One SETUP/STROBE/HOLD access on the async SRAM pins.
// A start in IDLE or HOLD begins the next access with no gap cycle.
module memory_sram8_byte_cycle
   import memory_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_ADDR_W = 20
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   write,
   input  logic [SRAM_ADDR_W-1:0] addr,
   input  logic [7:0]             wdata,
   output logic                   done,
   output logic [7:0]             rdata,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [7:0]             sram_dq_o,
   output logic                   sram_dq_oe,
   input  logic [7:0]             sram_dq_i,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n
);
   localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES);

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   write_q, write_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]             dq_o_q, dq_o_d;
   logic                   dq_oe_q, dq_oe_d;
   logic                   ce_n_q, ce_n_d;
   logic                   oe_n_q, oe_n_d;
   logic                   we_n_q, we_n_d;
   logic [7:0]             dq_sync_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      dq_o_d  = dq_o_q;
      case (state_q)
         IDLE, HOLD: state_d = start ? SETUP : IDLE;
         SETUP: begin
            state_d = STROBE;
            cnt_d   = STROBE_LAST;
         end
         STROBE: begin
            if (cnt_q == 4'd0) state_d = HOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      if (start && (state_q == IDLE || state_q == HOLD)) begin
         write_d = write;
         addr_d  = addr;
         if (write) dq_o_d = wdata;
      end
      // Pins are decoded from the next state so every one of them is a flop.
      ce_n_d  = (state_d == IDLE);
      oe_n_d  = !(state_d == STROBE && !write_d);
      we_n_d  = !(state_d == STROBE && write_d);
      dq_oe_d = write_d && (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= '0;
         dq_o_q  <= 8'h00;
         dq_oe_q <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         dq_o_q  <= dq_o_d;
         dq_oe_q <= dq_oe_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
      end
   end

   // Pad input sync: HOLD sees the byte sampled at the final STROBE edge.
   always_ff @(posedge clk) dq_sync_q <= sram_dq_i;

   assign done       = (state_q == HOLD);
   assign rdata      = dq_sync_q;
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
endmodule

// File: rtl/memory_sram8_responder.sv
// mem_bus responder for an 8-bit async SRAM: splits a 16-bit word into
// up to two byte accesses, skips masked write lanes and issues the ack.
module memory_sram8_responder
   import memory_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_ADDR_W = 20
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mem_bus_if.slave               mem_bus,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [7:0]             sram_dq_o,
   output logic                   sram_dq_oe,
   input  logic [7:0]             sram_dq_i,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n
);
   // Top-level state uses SETUP to mean "a byte access is running".
   state_e                 state_q, state_d;
   logic                   write_q, write_d;
   logic                   lane_q, lane_d;
   logic                   ack_q, ack_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [MASK_W-1:0]      wmask_q, wmask_d;
   logic [SRAM_ADDR_W-1:0] base_q, base_d;
   logic [7:0]             hi_q, hi_d;

   logic                   bc_start, bc_write, bc_done;
   logic [SRAM_ADDR_W-1:0] bc_addr;
   logic [7:0]             bc_wdata, bc_rdata;

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      lane_d   = lane_q;
      rdata_d  = rdata_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      base_d   = base_q;
      hi_d     = hi_q;
      bc_start = 1'b0;
      bc_write = write_q;
      bc_addr  = base_q | SRAM_ADDR_W'(lane_q);
      bc_wdata = lane_byte(wdata_q, lane_q);
      case (state_q)
         IDLE: begin
            if (mem_bus.request && !ack_q) begin
               write_d = mem_bus.write;
               wdata_d = mem_bus.wdata;
               wmask_d = mem_bus.wmask;
               base_d  = {mem_bus.address[SRAM_ADDR_W-1:1], 1'b0};
               lane_d  = (!mem_bus.write || mem_bus.wmask[1]) ? LANE_EVEN : LANE_ODD;
               if (mem_bus.write && mem_bus.wmask == '0) begin
                  state_d = ACK;
               end else begin
                  state_d  = SETUP;
                  bc_start = 1'b1;
                  bc_write = mem_bus.write;
                  bc_addr  = base_d | SRAM_ADDR_W'(lane_d);
                  bc_wdata = lane_byte(mem_bus.wdata, lane_d);
               end
            end
         end
         SETUP: begin
            if (bc_done) begin
               if (lane_q == LANE_EVEN) hi_d = bc_rdata;
               if (lane_q == LANE_EVEN && (!write_q || wmask_q[0])) begin
                  lane_d   = LANE_ODD;
                  bc_start = 1'b1;
                  bc_addr  = base_q | SRAM_ADDR_W'(LANE_ODD);
                  bc_wdata = lane_byte(wdata_q, LANE_ODD);
               end else begin
                  state_d = ACK;
                  if (!write_q) rdata_d = {hi_q, bc_rdata};
               end
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ack_d = (state_d == ACK);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         lane_q  <= LANE_EVEN;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         lane_q  <= lane_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      base_q  <= base_d;
      hi_q    <= hi_d;
   end

   assign mem_bus.ack   = ack_q;
   assign mem_bus.rdata = rdata_q;

   memory_sram8_byte_cycle #(
      .WAIT_CYCLES(WAIT_CYCLES),
      .SRAM_ADDR_W(SRAM_ADDR_W)
   ) u_byte_cycle (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (bc_start),
      .write      (bc_write),
      .addr       (bc_addr),
      .wdata      (bc_wdata),
      .done       (bc_done),
      .rdata      (bc_rdata),
      .sram_addr  (sram_addr),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_i  (sram_dq_i),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n)
   );
endmodule

// File: tb/tb_memory_sram8_responder.sv
// Scoreboard bench for memory_sram8_responder against a behavioural async SRAM.
`timescale 1ns/1ps
module tb_memory_sram8_responder;
   import memory_pkg::*;

   localparam int W  = 2;
   localparam int AW = 20;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_bus_if bus();
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_dq_o, sram_dq_i;
   logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

   memory_sram8_responder #(.WAIT_CYCLES(W), .SRAM_ADDR_W(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_bus    (bus),
      .sram_addr  (sram_addr),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_i  (sram_dq_i),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n)
   );

   // Behavioural SRAM: combinational read, write committed on the we_n rising edge.
   logic [7:0] mem [0:4095];
   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[11:0]] : 8'h00;
   always @(posedge sram_we_n) if (sram_ce_n === 1'b0) mem[sram_addr[11:0]] <= sram_dq_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [15:0] rdata;
      int          lat;
      int          issue;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    d;
      int            len;
      logic          ok;
   } pulse_t;
   pulse_t pq[$];
   pulse_t cur;

   int   ack_count = 0;
   int   last_ack_cyc = -100;
   int   ce_low_cnt = 0;
   logic ce_prev = 1'b1;
   logic we_prev = 1'b1;

   // Monitor: pops the scoreboard on every ack and tracks SRAM pin activity.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.ack === 1'b1) begin
            ack_count++;
            last_ack_cyc = cyc;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
               mon_e = sbq.pop_front();
               chk({mon_e.name, "_rdata"}, 32'(bus.rdata), 32'(mon_e.rdata));
               chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.issue), 32'(mon_e.lat));
            end
         end
         if (!sram_ce_n && ce_prev && last_ack_cyc >= 0)
            chk("ce_gap_ge2", 32'(cyc - last_ack_cyc >= 2), 32'd1);
      end
      if (!sram_ce_n) ce_low_cnt++;
      if (!sram_we_n) begin
         if (we_prev) begin
            cur.a = sram_addr; cur.d = sram_dq_o; cur.len = 1; cur.ok = sram_dq_oe;
         end else begin
            cur.len++;
            if (sram_addr !== cur.a || sram_dq_o !== cur.d || sram_dq_oe !== 1'b1) cur.ok = 1'b0;
         end
      end else if (!we_prev) begin
         pq.push_back(cur);
      end
      ce_prev = sram_ce_n;
      we_prev = sram_we_n;
   end

   task automatic wait_ack(input string name);
      int n = 0;
      @(negedge clk);
      while (bus.ack !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.ack !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout ack=0 required=1", name);
      end
   endtask

   task automatic issue(input string name, input logic wr, input logic [26:0] a,
                        input logic [15:0] wd, input logic [1:0] wm,
                        input logic [15:0] exp_rd, input int lat);
      exp_t e;
      @(posedge clk); #1;
      bus.request = 1'b1; bus.write = wr; bus.address = a; bus.wdata = wd; bus.wmask = wm;
      e.name = name; e.rdata = exp_rd; e.lat = lat; e.issue = cyc;
      sbq.push_back(e);
      wait_ack(name);
      @(posedge clk); #1;
      bus.request = 1'b0; bus.write = 1'b0;
   endtask

   task automatic check_pulse(input string name, input logic [AW-1:0] a, input logic [7:0] d);
      pulse_t p;
      if (pq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_missing pulses=0 required=1", name);
      end else begin
         p = pq.pop_front();
         chk({name, "_addr"}, 32'(p.a), 32'(a));
         chk({name, "_data"}, 32'(p.d), 32'(d));
         chk({name, "_len"}, 32'(p.len), 32'(W + 1));
         chk({name, "_stable"}, 32'(p.ok), 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int ce_before, acks_before;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h100] = 8'hA5; mem[12'h101] = 8'h3C;
      mem[12'h102] = 8'h5A; mem[12'h103] = 8'hC3;
      mem[12'h104] = 8'hDE; mem[12'h105] = 8'hAD;
      mem[12'h300] = 8'h77;
      bus.request = 1'b0; bus.write = 1'b0; bus.address = '0; bus.wdata = '0; bus.wmask = '0;

      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
      chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_pins_n", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);

      issue("rd100", 1'b0, 27'h100, 16'h0000, 2'b00, 16'hA53C, 11);
      chk("rd100_no_write", 32'(pq.size()), 32'd0);

      pq.delete();
      issue("wr200", 1'b1, 27'h200, 16'h1234, 2'b11, 16'hA53C, 11);
      repeat (2) @(negedge clk);
      chk("wr200_npulses", 32'(pq.size()), 32'd2);
      check_pulse("wr200_p1", 20'h200, 8'h12);
      check_pulse("wr200_p2", 20'h201, 8'h34);
      chk("wr200_mem0", 32'(mem[12'h200]), 32'h12);
      chk("wr200_mem1", 32'(mem[12'h201]), 32'h34);

      pq.delete();
      issue("wr301", 1'b1, 27'h301, 16'h1234, 2'b01, 16'hA53C, 6);
      repeat (2) @(negedge clk);
      chk("wr301_npulses", 32'(pq.size()), 32'd1);
      check_pulse("wr301_p1", 20'h301, 8'h34);
      chk("wr301_mem300", 32'(mem[12'h300]), 32'h77);
      chk("wr301_mem301", 32'(mem[12'h301]), 32'h34);

      pq.delete();
      issue("wr400", 1'b1, 27'h400, 16'hABCD, 2'b10, 16'hA53C, 6);
      repeat (2) @(negedge clk);
      chk("wr400_npulses", 32'(pq.size()), 32'd1);
      check_pulse("wr400_p1", 20'h400, 8'hAB);
      chk("wr400_mem401", 32'(mem[12'h401]), 32'h00);

      ce_before = ce_low_cnt;
      issue("wr600_m00", 1'b1, 27'h600, 16'hFFFF, 2'b00, 16'hA53C, 1);
      repeat (2) @(negedge clk);
      chk("wr600_ce_idle", 32'(ce_low_cnt - ce_before), 32'd0);
      chk("wr600_mem", 32'(mem[12'h600]), 32'h00);

      acks_before = ack_count;
      issue("burst0", 1'b0, 27'h100, 16'h0, 2'b00, 16'hA53C, 11);
      issue("burst1", 1'b0, 27'h103, 16'h0, 2'b00, 16'h5AC3, 11);
      issue("burst2", 1'b0, 27'h4100104, 16'h0, 2'b00, 16'hDEAD, 11);
      repeat (20) @(negedge clk);
      chk("burst_acks", 32'(ack_count - acks_before), 32'd3);
      chk("burst_sb_empty", 32'(sbq.size()), 32'd0);

      // Abort a two-lane write in the middle of its first strobe.
      @(posedge clk); #1;
      bus.request = 1'b1; bus.write = 1'b1; bus.address = 27'h500; bus.wdata = 16'h9876; bus.wmask = 2'b11;
      n = 0;
      while (sram_we_n !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_in_strobe", 32'(sram_we_n), 32'd0);
      #1 reset_n = 1'b0;
      bus.request = 1'b0;
      #1;
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
      chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("abort_ack", 32'(bus.ack), 32'd0);
      chk("abort_rdata", 32'(bus.rdata), 32'd0);
      acks_before = ack_count;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("abort_no_ack", 32'(ack_count - acks_before), 32'd0);
      pq.delete();

      issue("rd_after_rst", 1'b0, 27'h102, 16'h0, 2'b00, 16'h5AC3, 11);
      repeat (3) @(negedge clk);
      chk("final_sb_empty", 32'(sbq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
